// File: rtl/tune_sequencer.sv
// tune_sequencer: plays up to eight fixed tones with programmable note and
// gap lengths, feeding the FREQUENCY input of the AUDIO tone generator.
// Optional build macro: TUNE_LOOP_EN -- when defined the tune repeats until
// STOP, pulsing DONE once per pass; otherwise it plays once per START.
// Handshake: START is a single-cycle request, accepted only in IDLE and only
// when STOP is low; STOP returns the sequencer to IDLE on the next edge from
// any state. Outputs are registered, computed from the next state.
module tune_sequencer #(
  parameter int NOTE_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int NUM_NOTES   = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        STOP,
  output logic [15:0] FREQUENCY,
  output logic        TONE_EN,
  output logic        BUSY,
  output logic        DONE,
  output logic [2:0]  NOTE_IDX,
  output logic [1:0]  STATE_DBG
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [24:0] NOTE_LOAD = 25'(NOTE_CYCLES - 1);
  localparam logic [24:0] GAP_LOAD  = 25'(GAP_CYCLES - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(NUM_NOTES - 1);

  state_t      state, next_state;
  logic [24:0] cnt, next_cnt;
  logic [2:0]  next_idx;
  logic        next_done;

  // Fixed note table in Hz (C5 up to C6).
  function automatic logic [15:0] note_hz(input logic [2:0] i);
    case (i)
      3'd0:    note_hz = 16'd523;
      3'd1:    note_hz = 16'd587;
      3'd2:    note_hz = 16'd659;
      3'd3:    note_hz = 16'd698;
      3'd4:    note_hz = 16'd784;
      3'd5:    note_hz = 16'd880;
      3'd6:    note_hz = 16'd988;
      default: note_hz = 16'd1047;
    endcase
  endfunction

  assign STATE_DBG = state;

  // Next-state, duration counter and note index decisions.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_idx   = NOTE_IDX;
    next_done  = 1'b0;
    if (STOP) begin
      // Abort: index is kept so the last played note stays visible.
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            next_state = S_NOTE;
            next_idx   = 3'd0;
            next_cnt   = NOTE_LOAD;
          end
        end
        S_NOTE: begin
          if (cnt == 25'd0) begin
            if (NOTE_IDX != LAST_IDX) begin
              if (GAP_CYCLES > 0) begin
                next_state = S_GAP;
                next_cnt   = GAP_LOAD;
              end else begin
                next_idx = NOTE_IDX + 3'd1;
                next_cnt = NOTE_LOAD;
              end
            end else begin
              next_done = 1'b1;
`ifdef TUNE_LOOP_EN
              if (GAP_CYCLES > 0) begin
                next_state = S_GAP;
                next_cnt   = GAP_LOAD;
              end else begin
                next_idx = 3'd0;
                next_cnt = NOTE_LOAD;
              end
`else
              next_state = S_IDLE;
`endif
            end
          end else begin
            next_cnt = cnt - 25'd1;
          end
        end
        S_GAP: begin
          if (cnt == 25'd0) begin
            next_state = S_NOTE;
            next_cnt   = NOTE_LOAD;
            // Wrap only happens on the trailing gap of a looping pass.
            next_idx   = (NOTE_IDX == LAST_IDX) ? 3'd0 : NOTE_IDX + 3'd1;
          end else begin
            next_cnt = cnt - 25'd1;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      cnt       <= 25'd0;
      NOTE_IDX  <= 3'd0;
      FREQUENCY <= 16'd0;
      TONE_EN   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      NOTE_IDX  <= next_idx;
      FREQUENCY <= (next_state == S_NOTE) ? note_hz(next_idx) : 16'd0;
      TONE_EN   <= (next_state == S_NOTE);
      BUSY      <= (next_state != S_IDLE);
      DONE      <= next_done;
    end
  end

endmodule
